// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the control sequencer.
// Instruction layout: type[IW-1:IW-2], op[IW-3:IW-5], funct[3:0].
package ctrl_pkg;

  typedef enum logic [1:0] {
    TYPE_R = 2'b00,
    TYPE_M = 2'b01,
    TYPE_B = 2'b10,
    TYPE_S = 2'b11
  } instr_type_e;

  // M-type op codes (op values 100..110 are plain register writes)
  localparam logic [2:0] MOP_STORE = 3'b000;
  localparam logic [2:0] MOP_LDB   = 3'b001;
  localparam logic [2:0] MOP_LUT0  = 3'b010;
  localparam logic [2:0] MOP_LUT1  = 3'b011;
  localparam logic [2:0] MOP_HALT  = 3'b111;

  // R-type funct codes; 0000..FUNCT_SUB are register-writing ALU ops
  localparam logic [3:0] FUNCT_SUB  = 4'b0100;
  localparam logic [3:0] FUNCT_SLT  = 4'b0101;
  localparam logic [3:0] FUNCT_SLTE = 4'b0110;
  localparam logic [3:0] FUNCT_EQ   = 4'b0111;

  // B-type and S-type sub-ops, decoded on op[2:1]
  localparam logic [1:0] BOP_BEQ  = 2'b00;
  localparam logic [1:0] BOP_BLT  = 2'b01;
  localparam logic [1:0] BOP_BLTE = 2'b10;
  localparam logic [1:0] BOP_BUN  = 2'b11;
  localparam logic [1:0] SOP_LSL  = 2'b00;
  localparam logic [1:0] SOP_LSR  = 2'b01;
  localparam logic [1:0] SOP_BF   = 2'b10;
  localparam logic [1:0] SOP_BB   = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_LOAD_WAIT = 2'b01,
    ST_HALT      = 2'b10
  } state_e;

  // One beat of control; the upd_*/lt_incl_eq fields say how a compare
  // in the output stage updates (and forwards) the flags.
  typedef struct packed {
    logic       branch_en;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       lut_en;
    logic [2:0] alu_op;
    logic       shift_dir;
    logic       upd_eq;
    logic       upd_lt;
    logic       lt_incl_eq;
  } ctrl_t;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: instruction fetch handshake into the sequencer.
interface ctrl_sequencer_if #(
  parameter int IW = 9
) ();
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic          instr_ready;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational instruction decode into a control beat.
// Branch conditions use the effective (possibly forwarded) flags.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int IW = 9
) (
  input  logic [IW-1:0] instr_i,
  input  logic          eq_eff_i,
  input  logic          lt_eff_i,
  output ctrl_t         ctrl_o,
  output logic          is_load_o,
  output logic          is_halt_o
);

  instr_type_e itype;
  logic [2:0]  op;
  logic [1:0]  sub;
  logic [3:0]  funct;

  // Field extraction and per-type decode
  always_comb begin
    itype     = instr_type_e'(instr_i[IW-1:IW-2]);
    op        = instr_i[IW-3:IW-5];
    sub       = op[2:1];
    funct     = instr_i[3:0];
    ctrl_o    = '0;
    is_load_o = 1'b0;
    is_halt_o = 1'b0;
    unique case (itype)
      TYPE_R: begin
        ctrl_o.alu_op = op;
        if (funct <= FUNCT_SUB) begin
          ctrl_o.reg_write = 1'b1;
        end else begin
          case (funct)
            FUNCT_SLT:  ctrl_o.upd_lt = 1'b1;
            FUNCT_SLTE: begin
              ctrl_o.upd_lt     = 1'b1;
              ctrl_o.lt_incl_eq = 1'b1;
            end
            FUNCT_EQ:   ctrl_o.upd_eq = 1'b1;
            default:    ;
          endcase
        end
      end
      TYPE_M: begin
        case (op)
          MOP_STORE: ctrl_o.mem_write = 1'b1;
          MOP_LDB: begin
            ctrl_o.mem_read = 1'b1;
            is_load_o       = 1'b1;
          end
          MOP_LUT0, MOP_LUT1: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.lut_en   = 1'b1;
          end
          MOP_HALT:  is_halt_o = 1'b1;
          default:   ctrl_o.reg_write = 1'b1;
        endcase
      end
      TYPE_B: begin
        case (sub)
          BOP_BEQ:  ctrl_o.branch_en = eq_eff_i;
          BOP_BLT:  ctrl_o.branch_en = lt_eff_i;
          BOP_BLTE: ctrl_o.branch_en = lt_eff_i | eq_eff_i;
          BOP_BUN:  ctrl_o.branch_en = 1'b1;
          default:  ;
        endcase
      end
      TYPE_S: begin
        case (sub)
          SOP_LSL, SOP_LSR: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.shift_dir = op[1];
          end
          SOP_BF:  ctrl_o.branch_en = eq_eff_i;
          SOP_BB:  ctrl_o.branch_en = lt_eff_i;
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: registered control sequencer between fetch and datapath.
// Holds compare flags, sequences load-byte (MEM_LAT wait) and halt.
// Optional macro CTRL_BRANCH_FLUSH_EN: squash the instruction accepted while
// a taken branch is in the output stage (otherwise it is a delay slot).
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int IW      = 9,
  parameter int LW      = 5,
  parameter int SW      = 3,
  parameter int MEM_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  ctrl_sequencer_if.slave        fetch,
  input  logic                   cmp_equal,
  input  logic                   cmp_less,
  output logic                   ctrl_valid,
  output logic                   branch_en,
  output logic                   mem_write,
  output logic                   mem_read,
  output logic                   reg_write,
  output logic                   lut_en,
  output logic [LW-1:0]          lut_index,
  output logic [2:0]             alu_op,
  output logic                   shift_dir,
  output logic [SW-1:0]          shift_amt,
  output logic                   flag_eq,
  output logic                   flag_lt,
  output logic                   halted
);

  localparam int CW = $clog2(MEM_LAT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctrl_t         out_q, out_d, dec;
  logic          valid_q, valid_d;
  logic [LW-1:0] lut_q, lut_d;
  logic [SW-1:0] shamt_q, shamt_d;
  logic          flag_eq_q, flag_lt_q;
  logic          eq_eff, lt_eff, accept, squash, dec_load, dec_halt;

  assign fetch.instr_ready = (state_q == ST_RUN);
  assign accept            = fetch.instr_valid && fetch.instr_ready;

  // A compare sitting in the output stage forwards its live ALU result.
  assign eq_eff = (valid_q && out_q.upd_eq) ? cmp_equal : flag_eq_q;
  assign lt_eff = (valid_q && out_q.upd_lt) ?
                  (cmp_less | (out_q.lt_incl_eq & cmp_equal)) : flag_lt_q;

`ifdef CTRL_BRANCH_FLUSH_EN
  assign squash = out_q.branch_en;
`else
  assign squash = 1'b0;
`endif

  ctrl_decode #(.IW(IW)) u_decode (
    .instr_i   (fetch.instr),
    .eq_eff_i  (eq_eff),
    .lt_eff_i  (lt_eff),
    .ctrl_o    (dec),
    .is_load_o (dec_load),
    .is_halt_o (dec_halt)
  );

  // Next state, load counter and next control beat
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = '0;
    valid_d = 1'b0;
    lut_d   = '0;
    shamt_d = '0;
    case (state_q)
      ST_RUN: begin
        if (accept && !squash) begin
          if (dec_halt) begin
            state_d = ST_HALT;
          end else begin
            out_d   = dec;
            valid_d = 1'b1;
            lut_d   = fetch.instr[LW-1:0];
            shamt_d = fetch.instr[SW-1:0];
            if (dec_load) begin
              state_d = ST_LOAD_WAIT;
              cnt_d   = '0;
            end
          end
        end
      end
      ST_LOAD_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MEM_LAT - 1)) begin
          out_d.reg_write = 1'b1;
          valid_d         = 1'b1;
        end
        if (cnt_q == CW'(MEM_LAT)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // FSM state and load counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output stage registers and compare flags
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      out_q     <= '0;
      lut_q     <= '0;
      shamt_q   <= '0;
      flag_eq_q <= 1'b0;
      flag_lt_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      out_q     <= out_d;
      lut_q     <= lut_d;
      shamt_q   <= shamt_d;
      flag_eq_q <= eq_eff;
      flag_lt_q <= lt_eff;
    end
  end

  assign ctrl_valid = valid_q;
  assign branch_en  = out_q.branch_en;
  assign mem_write  = out_q.mem_write;
  assign mem_read   = out_q.mem_read;
  assign reg_write  = out_q.reg_write;
  assign lut_en     = out_q.lut_en;
  assign alu_op     = out_q.alu_op;
  assign shift_dir  = out_q.shift_dir;
  assign lut_index  = lut_q;
  assign shift_amt  = shamt_q;
  assign flag_eq    = flag_eq_q;
  assign flag_lt    = flag_lt_q;
  assign halted     = (state_q == ST_HALT);

endmodule
